// File: rtl/huffman_pkg.sv
// huffman_pkg: shared state encoding and widths for the Huffman encoder blocks
package huffman_pkg;
  localparam int NUM_SYM = 6;
  localparam int CNT_W = 8;
  localparam int STEP_W = 3;
  typedef enum logic [4:0] {
    IDLE, REC, CNT_OUT, SORT_GO, SORT_WAIT, MERGE, SPLIT, DONE, ERR
  } state_e;
  function automatic logic is_wait(input state_e s);
    return s inside {SORT_WAIT, MERGE, SPLIT};
  endfunction
endpackage

// File: rtl/hs_watchdog.sv
// hs_watchdog: cycle counter that flags expiry after TIMEOUT cycles in a wait state
module hs_watchdog import huffman_pkg::*; #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = enable && cnt_q == CNT_W'(TIMEOUT - 1);
endmodule

// File: rtl/huffman_seq.sv
// huffman_seq: frame sequencer for the Huffman encoder (sample burst, sort, merge, split handshakes)
module huffman_seq import huffman_pkg::*; #(
  parameter int NUM_SYM = 6,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_valid,
  output logic              cnt_valid,
  output logic              sort_start,
  input  logic              sort_done,
  output logic              merge_req,
  output logic [STEP_W-1:0] merge_step,
  input  logic              merge_ack,
  output logic              split_req,
  input  logic              split_ack,
  output logic              code_valid,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic              busy,
  output logic              err
);
  localparam logic [STEP_W-1:0] LAST = STEP_W'(NUM_SYM - 2);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic expired, last_step, step_adv;
  assign last_step = step_q >= LAST;
  assign step_adv = state_q == MERGE && merge_ack && !last_step;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = gray_valid ? REC : IDLE;
      REC:       state_d = gray_valid ? REC : CNT_OUT;
      CNT_OUT:   state_d = SORT_GO;
      SORT_GO:   state_d = SORT_WAIT;
      SORT_WAIT: state_d = sort_done ? MERGE : expired ? ERR : SORT_WAIT;
      MERGE:     state_d = merge_ack ? (last_step ? SPLIT : MERGE) : expired ? ERR : MERGE;
      SPLIT:     state_d = split_ack ? DONE : expired ? ERR : SPLIT;
      default:   state_d = IDLE;
    endcase
  end
  always_comb begin
    step_d = state_d != MERGE ? '0 : state_q != MERGE ? STEP_W'(1) : step_adv ? step_q + 1'b1 : step_q;
    cnt_d = state_q == IDLE && gray_valid ? CNT_W'(1)
          : state_q == REC && gray_valid && cnt_q != '1 ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      step_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      step_q <= step_d;
    end
  // a handshake in the expiry cycle still wins because the FSM checks it first
  hs_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk),
    .reset(reset),
    .clear(state_d != state_q || step_adv),
    .enable(is_wait(state_q)),
    .expired(expired)
  );
  assign cnt_valid  = state_q == CNT_OUT;
  assign sort_start = state_q == SORT_GO;
  assign merge_req  = state_q == MERGE;
  assign split_req  = state_q == SPLIT;
  assign code_valid = state_q == DONE;
  assign err        = state_q == ERR;
  assign busy       = state_q != IDLE;
  assign merge_step = step_q;
  assign sample_cnt = cnt_q;
endmodule

// File: tb/tb_huffman_seq.sv
// tb_huffman_seq: directed checks of the Huffman frame sequencer
module tb_huffman_seq;
  logic clk = 0, reset = 1, gray_valid = 0, sort_done = 0, merge_ack = 0, split_ack = 0;
  logic cnt_valid, sort_start, merge_req, split_req, code_valid, busy, err;
  logic [2:0] merge_step;
  logic [7:0] sample_cnt;
  int n_checks = 0, n_fail = 0, n_xfer = 0, x0;
  localparam logic [6:0] B = 7'b1000000, CV = 7'b0100000, SS = 7'b0010000, MR = 7'b0001000,
                         SR = 7'b0000100, DN = 7'b0000010, ER = 7'b0000001;
  always #5 clk = ~clk;
  huffman_seq dut (
    .clk(clk), .reset(reset), .gray_valid(gray_valid), .cnt_valid(cnt_valid),
    .sort_start(sort_start), .sort_done(sort_done), .merge_req(merge_req),
    .merge_step(merge_step), .merge_ack(merge_ack), .split_req(split_req),
    .split_ack(split_ack), .code_valid(code_valid), .sample_cnt(sample_cnt),
    .busy(busy), .err(err)
  );
  wire [6:0] o = {busy, cnt_valid, sort_start, merge_req, split_req, code_valid, err};
  always @(posedge clk) if (merge_req && merge_ack) n_xfer++;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic frame(input int n);
    gray_valid = 1;
    repeat (n) tick();
    gray_valid = 0;
    tick();
  endtask
  task automatic goto_merge();
    frame(2);
    tick();
    tick();
    sort_done = 1;
    tick();
    sort_done = 0;
  endtask
  task automatic run_to_done(input string tag);
    sort_done = 1;
    merge_ack = 1;
    split_ack = 1;
    for (int i = 0; i < 30 && !code_valid; i++) tick();
    check(tag, code_valid, 1);
    tick();
    check({tag, "_idle"}, o, 0);
    sort_done = 0;
    merge_ack = 0;
    split_ack = 0;
  endtask
  initial begin
    repeat (2) tick();
    check("rst_out", o, 0);
    check("rst_cnt", sample_cnt, 0);
    check("rst_step", merge_step, 0);
    reset = 0;
    // nominal frame, handshakes tied high
    sort_done = 1; merge_ack = 1; split_ack = 1;
    gray_valid = 1;
    tick();
    check("nom_rec", o, B);
    check("nom_first", sample_cnt, 1);
    repeat (9) tick();
    gray_valid = 0;
    check("nom_cnt", sample_cnt, 10);
    tick();
    check("nom_cnt_valid", o, B | CV);
    tick();
    check("nom_sort_start", o, B | SS);
    tick();
    check("nom_sort_wait", o, B);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("nom_merge", o, B | MR);
      check("nom_step", k, merge_step);
    end
    tick();
    check("nom_split", o, B | SR);
    check("nom_step0", merge_step, 0);
    tick();
    check("nom_done", o, B | DN);
    gray_valid = 1;
    tick();
    check("done_gv_ignored", o, 0);
    check("nom_cnt_hold", sample_cnt, 10);
    gray_valid = 0;
    // delayed handshakes
    sort_done = 0; merge_ack = 0; split_ack = 0;
    frame(3);
    check("dly_cnt_valid", o, B | CV);
    tick();
    tick();
    gray_valid = 1;
    repeat (4) begin
      tick();
      check("dly_sort_wait", o, B);
    end
    gray_valid = 0;
    check("dly_gv_ignored", sample_cnt, 3);
    sort_done = 1;
    tick();
    sort_done = 0;
    x0 = n_xfer;
    for (int k = 1; k <= 4; k++) begin
      check("dly_merge", o, B | MR);
      check("dly_step", merge_step, k);
      repeat (2) begin
        tick();
        check("dly_step_hold", merge_step, k);
      end
      merge_ack = 1;
      tick();
      merge_ack = 0;
    end
    check("dly_split", o, B | SR);
    check("dly_xfers", n_xfer - x0, 4);
    repeat (6) begin
      tick();
      check("dly_split_hold", o, B | SR);
    end
    split_ack = 1;
    tick();
    split_ack = 0;
    check("dly_done", o, B | DN);
    tick();
    check("dly_idle", o, 0);
    // watchdog expiry in merge step 2
    merge_ack = 1;
    goto_merge();
    tick();
    merge_ack = 0;
    check("to_step2", merge_step, 2);
    repeat (63) tick();
    check("to_last_wait", o, B | MR);
    tick();
    check("to_err", o, B | ER);
    check("to_err_step", merge_step, 0);
    tick();
    check("to_idle", o, 0);
    // ack in the expiry cycle wins
    merge_ack = 1;
    goto_merge();
    tick();
    merge_ack = 0;
    repeat (63) tick();
    merge_ack = 1;
    tick();
    check("to_ack63", o, B | MR);
    check("to_ack63_step", merge_step, 3);
    run_to_done("to_ack63_done");
    // saturation
    frame(300);
    check("sat_cnt", sample_cnt, 255);
    check("sat_cnt_valid", o, B | CV);
    run_to_done("sat_done");
    // reset in merge step 3
    merge_ack = 1;
    goto_merge();
    tick();
    tick();
    merge_ack = 0;
    check("rm_step3", merge_step, 3);
    reset = 1;
    tick();
    reset = 0;
    check("rm_out", o, 0);
    check("rm_cnt", sample_cnt, 0);
    check("rm_step", merge_step, 0);
    frame(4);
    check("rm_frame_cnt", sample_cnt, 4);
    run_to_done("rm_frame_done");
    // sort_done in SORT_GO is ignored
    frame(5);
    tick();
    check("early_sort_go", o, B | SS);
    sort_done = 1;
    tick();
    sort_done = 0;
    check("early_wait0", o, B);
    repeat (3) begin
      tick();
      check("early_wait", o, B);
    end
    sort_done = 1;
    tick();
    check("early_merge", o, B | MR);
    check("early_step", merge_step, 1);
    run_to_done("early_done");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
